// File: rtl/tt_pkg.sv
// tt_pkg: grid constants, cursor FSM states, button bit positions and the wrapping next-cell step
package tt_pkg;
  localparam int NUM_CELLS = 9;
  localparam int ROW_W = 3;
  localparam int POS_W = 4;
  localparam int B_RIGHT = 0;
  localparam int B_LEFT = 1;
  localparam int B_DOWN = 2;
  localparam int B_UP = 3;
  localparam int B_SEL = 4;
  typedef enum logic [1:0] {IDLE, READY, SEEK, FULL} cursor_state_e;
  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP} dir_e;
  function automatic logic [POS_W-1:0] next_cell(input logic [POS_W-1:0] p, input dir_e d);
    logic [POS_W:0] s;
    s = {1'b0, p} + (d == DIR_RIGHT ? (POS_W+1)'(1) :
                     d == DIR_LEFT  ? (POS_W+1)'(NUM_CELLS - 1) :
                     d == DIR_DOWN  ? (POS_W+1)'(ROW_W) :
                                      (POS_W+1)'(NUM_CELLS - ROW_W));
    return POS_W'(s >= (POS_W+1)'(NUM_CELLS) ? s - (POS_W+1)'(NUM_CELLS) : s);
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: registers 5 button levels and flags rising edges; in: clk, rst_n, btn[4:0]; out: rise[4:0]
module btn_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn,
  output logic [4:0] rise
);
  logic [4:0] prev_q, prev_d;
  always_comb prev_d = btn;
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= '0;
    else prev_q <= prev_d;
  end
  assign rise = btn & ~prev_q;
endmodule

// File: rtl/cursor_enc.sv
// cursor_enc: 3x3 cursor with select/place strobe and free-cell seek; in: clk, rst_n, game_active, btn_up/down/left/right/sel, occupied[8:0]; out: pos[3:0], place_en, reject, board_full, busy
module cursor_enc
  import tt_pkg::*;
#(
  parameter int unsigned START_POS = 4,
  parameter bit          SEL_PRIO  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             game_active,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_sel,
  input  logic [8:0]       occupied,
  output logic [POS_W-1:0] pos,
  output logic             place_en,
  output logic             reject,
  output logic             board_full,
  output logic             busy
);
  localparam logic [POS_W-1:0] START = POS_W'(START_POS);
  cursor_state_e state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, placed_q, placed_d, cand;
  logic [2:0] cnt_q, cnt_d;
  logic place_en_q, place_en_d, reject_q, reject_d;
  logic [4:0] rise;
  logic sel_win, mv, cand_free;
  dir_e mv_dir;
  btn_edge u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  ({btn_sel, btn_up, btn_down, btn_left, btn_right}),
    .rise (rise)
  );
  assign sel_win = rise[B_SEL] && (SEL_PRIO || rise[3:0] == 4'b0);
  assign mv = |rise[3:0] && !sel_win;
  assign mv_dir = rise[B_UP] ? DIR_UP : rise[B_DOWN] ? DIR_DOWN : rise[B_LEFT] ? DIR_LEFT : DIR_RIGHT;
  assign cand = next_cell(pos_q, DIR_RIGHT);
  // occupied lags the strobe by a cycle, so the just-placed cell is masked here
  assign cand_free = !occupied[cand] && cand != placed_q;
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    placed_d = placed_q;
    cnt_d = cnt_q;
    place_en_d = 1'b0;
    reject_d = 1'b0;
    if (!game_active) begin
      state_d = IDLE;
      pos_d = START;
    end else begin
      case (state_q)
        IDLE: state_d = READY;
        READY: begin
          if (sel_win && occupied[pos_q]) reject_d = 1'b1;
          else if (sel_win) begin
            place_en_d = 1'b1;
            placed_d = pos_q;
            cnt_d = '0;
            state_d = SEEK;
          end else if (mv) pos_d = next_cell(pos_q, mv_dir);
        end
        SEEK: begin
          cnt_d = cnt_q + 3'd1;
          pos_d = cand;
          if (cand_free) state_d = READY;
          else if (cnt_q == 3'd7) begin
            state_d = FULL;
            pos_d = placed_q;
          end
        end
        FULL: state_d = FULL;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q <= START;
      placed_q <= '0;
      cnt_q <= '0;
      place_en_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      placed_q <= placed_d;
      cnt_q <= cnt_d;
      place_en_q <= place_en_d;
      reject_q <= reject_d;
    end
  end
  assign pos = pos_q;
  assign place_en = place_en_q;
  assign reject = reject_q;
  assign board_full = state_q == FULL;
  assign busy = state_q == SEEK;
endmodule

// File: tb/tb_cursor_enc.sv
// tb_cursor_enc: random and directed stimulus checked every cycle against a behavioural cursor model
module tb_cursor_enc;
  localparam int START = 4;
  localparam bit SEL_PRIO = 1'b1;
  logic clk = 1'b0;
  logic rst_n, game_active;
  logic [4:0] btn;
  logic [8:0] occupied;
  logic [3:0] pos;
  logic place_en, reject, board_full, busy;
  int checks = 0, errors = 0;
  bit started = 0;
  int m_mode, m_pos, m_placed, m_k;
  bit m_pe, m_rj;
  logic [4:0] m_prev;
  int prio[5];
  int step[4] = '{1, 8, 3, 6};
  int exp_seek[7] = '{6, 7, 8, 0, 1, 2, 3};
  cursor_enc #(.START_POS(START), .SEL_PRIO(SEL_PRIO)) dut (
    .clk(clk), .rst_n(rst_n), .game_active(game_active),
    .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]), .btn_sel(btn[4]),
    .occupied(occupied), .pos(pos), .place_en(place_en), .reject(reject),
    .board_full(board_full), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // model: mode 0 idle, 1 ready, 2 seeking (k steps past placed cell), 3 full
  always @(posedge clk) begin
    logic [4:0] ev;
    int w, c;
    if (!rst_n) begin
      started = 1;
      m_mode = 0; m_pos = START; m_pe = 0; m_rj = 0; m_prev = '0; m_placed = 0; m_k = 0;
    end else begin
      ev = btn & ~m_prev;
      m_prev = btn;
      m_pe = 0;
      m_rj = 0;
      if (!game_active) begin
        m_mode = 0;
        m_pos = START;
      end else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        w = -1;
        for (int j = 0; j < 5; j++) if (w < 0 && ev[prio[j]]) w = prio[j];
        if (w == 4) begin
          if (occupied[m_pos]) m_rj = 1;
          else begin
            m_pe = 1; m_placed = m_pos; m_k = 0; m_mode = 2;
          end
        end else if (w >= 0) m_pos = (m_pos + step[w]) % 9;
      end else if (m_mode == 2) begin
        m_k++;
        c = (m_placed + m_k) % 9;
        if (!occupied[c] && c != m_placed) begin
          m_pos = c; m_mode = 1;
        end else if (m_k == 8) begin
          m_pos = m_placed; m_mode = 3;
        end else m_pos = c;
      end
    end
  end
  always @(negedge clk) if (started) begin
    chk("pos", int'(pos), m_pos);
    chk("place_en", int'(place_en), int'(m_pe));
    chk("reject", int'(reject), int'(m_rj));
    chk("board_full", int'(board_full), int'(m_mode == 3));
    chk("busy", int'(busy), int'(m_mode == 2));
    chk("strobe_excl", int'(place_en & reject), 0);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [4:0] b);
    btn = b;
    cyc();
    btn = '0;
    cyc();
  endtask
  initial begin
    if (SEL_PRIO) prio = '{4, 3, 2, 1, 0};
    else prio = '{3, 2, 1, 0, 4};
    rst_n = 0; game_active = 0; btn = '0; occupied = '0;
    cyc(); cyc();
    chk("rst_pos", int'(pos), 4);
    chk("rst_full", int'(board_full), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1; game_active = 1;
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      press(5'b00001);
      chk("right_seq", int'(pos), 5 + i);
    end
    press(5'b00001);
    chk("right_wrap", int'(pos), 0);
    press(5'b00010);
    chk("left_wrap", int'(pos), 8);
    press(5'b00001);
    press(5'b00001);
    chk("pos_one", int'(pos), 1);
    press(5'b01000);
    chk("up_1_to_7", int'(pos), 7);
    press(5'b00100);
    chk("down_7_to_1", int'(pos), 1);
    press(5'b00010);
    btn = 5'b10000;
    cyc();
    chk("sel_place_en", int'(place_en), 1);
    chk("sel_pos", int'(pos), 0);
    chk("sel_busy", int'(busy), 1);
    btn = '0;
    occupied = 9'b000000001;
    cyc();
    chk("seek_done_pos", int'(pos), 1);
    chk("seek_done_busy", int'(busy), 0);
    occupied = 9'b000000111;
    press(5'b00010);
    btn = 5'b10000;
    cyc();
    chk("rej_reject", int'(reject), 1);
    chk("rej_place", int'(place_en), 0);
    chk("rej_pos", int'(pos), 0);
    btn = '0;
    cyc();
    chk("rej_one_cycle", int'(reject), 0);
    occupied = 9'b111011111;
    press(5'b00100);
    press(5'b00001);
    press(5'b00001);
    chk("pos_five", int'(pos), 5);
    btn = 5'b10000;
    cyc();
    chk("full_place", int'(place_en), 1);
    btn = '0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("seek_walk", int'(pos), exp_seek[i]);
    end
    cyc();
    chk("full_flag", int'(board_full), 1);
    chk("full_pos", int'(pos), 5);
    press(5'b00001);
    chk("full_ignores", int'(pos), 5);
    game_active = 0;
    cyc();
    chk("drop_full", int'(board_full), 0);
    game_active = 1;
    occupied = 9'b111101111;
    cyc();
    btn = 5'b10001;
    cyc();
    chk("prio_place", int'(place_en), 1);
    chk("prio_pos", int'(pos), 4);
    btn = '0;
    cyc(); cyc();
    game_active = 0;
    cyc();
    chk("abort_pos", int'(pos), 4);
    chk("abort_busy", int'(busy), 0);
    chk("abort_full", int'(board_full), 0);
    game_active = 1;
    occupied = '0;
    for (int n = 0; n < 4000; n++) begin
      rst_n = $urandom_range(0, 299) != 0;
      game_active = $urandom_range(0, 149) != 0;
      for (int j = 0; j < 5; j++) btn[j] = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0: occupied = 9'($urandom);
          1: occupied = 9'h1FF;
          default: occupied = 9'h1FF & ~(9'd1 << $urandom_range(0, 8));
        endcase
      end
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
